// File: rtl/utmi_tx_sched.sv
// utmi_tx_sched -- UTMI transmit scheduler (60 MHz UTMI clock domain).
//
// Arbitrates a one-byte handshake source against a streaming data-packet
// source. Handshake has fixed priority. Drives TXValid/DataIn with the UTMI
// byte handshake and enforces an inter-packet gap. No packet starts while
// RXActive is high. Detects data underrun and a stalled TXReady.
//
// Ports:
//   clk_60mhz, rst          clock, asynchronous active-high reset
//   hs_req/hs_pid/hs_gnt    handshake source (hs_gnt combinational)
//   dat_valid/dat_data/
//   dat_last/dat_ready      data source (dat_ready combinational)
//   RXActive                PHY receiving, gates new packet starts
//   TXReady                 PHY accepted current DataIn
//   TXValid/DataIn          registered PHY transmit byte handshake
//   tx_busy                 scheduler not idle
//   tx_done                 one-clock pulse, packet fully accepted
//   tx_err                  one-clock pulse: 00 none, 01 underrun, 10 timeout
//   tx_bytes                bytes accepted in current/last packet (saturating)
module utmi_tx_sched #(
  parameter int unsigned IPG_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_60mhz,
  input  logic        rst,
  input  logic        hs_req,
  input  logic [7:0]  hs_pid,
  output logic        hs_gnt,
  input  logic        dat_valid,
  input  logic [7:0]  dat_data,
  input  logic        dat_last,
  output logic        dat_ready,
  input  logic        RXActive,
  input  logic        TXReady,
  output logic        TXValid,
  output logic [7:0]  DataIn,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [1:0]  tx_err,
  output logic [10:0] tx_bytes
);

  // Stall counter only needs to reach TIMEOUT_CYCLES-1; gap counter holds IPG_CYCLES.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GW = $clog2(IPG_CYCLES + 1);

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] IPG_LOAD = GW'(IPG_CYCLES);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNDERRUN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_HS, S_DATA, S_GAP} state_t;

  state_t        state_q, state_d;
  logic          txvalid_q, txvalid_d;
  logic [7:0]    datain_q, datain_d;
  logic          last_q, last_d;
  logic [10:0]   bytes_q, bytes_d;
  logic          done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [TW-1:0] to_q, to_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          end_pkt;
  logic [10:0]   bytes_inc;

  assign bytes_inc = (bytes_q == '1) ? bytes_q : bytes_q + 11'd1;

  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      txvalid_q <= 1'b0;
      datain_q  <= '0;
      last_q    <= 1'b0;
      bytes_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= ERR_NONE;
      to_q      <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      txvalid_q <= txvalid_d;
      datain_q  <= datain_d;
      last_q    <= last_d;
      bytes_q   <= bytes_d;
      done_q    <= done_d;
      err_q     <= err_d;
      to_q      <= to_d;
      gap_q     <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    txvalid_d = txvalid_q;
    datain_d  = datain_q;
    last_d    = last_q;
    bytes_d   = bytes_q;
    done_d    = 1'b0;
    err_d     = ERR_NONE;
    to_d      = to_q;
    gap_d     = gap_q;
    end_pkt   = 1'b0;
    hs_gnt    = 1'b0;
    dat_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        // rst gates the combinational grants; state_q is already IDLE under reset.
        if (!rst && !RXActive) begin
          if (hs_req) begin
            hs_gnt    = 1'b1;
            datain_d  = hs_pid;
            state_d   = S_HS;
            txvalid_d = 1'b1;
            bytes_d   = '0;
            to_d      = '0;
          end else if (dat_valid) begin
            dat_ready = 1'b1;
            datain_d  = dat_data;
            last_d    = dat_last;
            state_d   = S_DATA;
            txvalid_d = 1'b1;
            bytes_d   = '0;
            to_d      = '0;
          end
        end
      end
      S_HS: begin
        if (TXReady) begin
          bytes_d = 11'd1;
          done_d  = 1'b1;
          end_pkt = 1'b1;
        end else if (to_q == TO_LAST) begin
          err_d   = ERR_TIMEOUT;
          end_pkt = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_DATA: begin
        if (TXReady) begin
          bytes_d = bytes_inc;
          if (last_q) begin
            done_d  = 1'b1;
            end_pkt = 1'b1;
          end else if (dat_valid) begin
            // Next byte is taken in the same cycle the PHY accepts the current one.
            dat_ready = 1'b1;
            datain_d  = dat_data;
            last_d    = dat_last;
            to_d      = '0;
          end else begin
            err_d   = ERR_UNDERRUN;
            end_pkt = 1'b1;
          end
        end else if (to_q == TO_LAST) begin
          err_d   = ERR_TIMEOUT;
          end_pkt = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q <= GAP_ONE) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_pkt) begin
      state_d   = S_GAP;
      txvalid_d = 1'b0;
      to_d      = '0;
      gap_d     = IPG_LOAD;
    end
  end

  assign TXValid  = txvalid_q;
  assign DataIn   = datain_q;
  assign tx_busy  = (state_q != S_IDLE);
  assign tx_done  = done_q;
  assign tx_err   = err_q;
  assign tx_bytes = bytes_q;

endmodule

// File: tb/tb_utmi_tx_sched.sv
module tb_utmi_tx_sched;
  localparam int unsigned IPG = 6;
  localparam int unsigned TO  = 4;

  logic        clk_60mhz = 1'b0;
  logic        rst = 1'b0;
  logic        hs_req = 1'b0;
  logic [7:0]  hs_pid = 8'h00;
  logic        hs_gnt;
  logic        dat_valid = 1'b0;
  logic [7:0]  dat_data = 8'h00;
  logic        dat_last = 1'b0;
  logic        dat_ready;
  logic        RXActive = 1'b0;
  logic        TXReady = 1'b0;
  logic        TXValid;
  logic [7:0]  DataIn;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  tx_err;
  logic [10:0] tx_bytes;

  always #8 clk_60mhz = ~clk_60mhz;

  utmi_tx_sched #(.IPG_CYCLES(IPG), .TIMEOUT_CYCLES(TO)) dut (
    .clk_60mhz(clk_60mhz), .rst(rst),
    .hs_req(hs_req), .hs_pid(hs_pid), .hs_gnt(hs_gnt),
    .dat_valid(dat_valid), .dat_data(dat_data), .dat_last(dat_last), .dat_ready(dat_ready),
    .RXActive(RXActive), .TXReady(TXReady),
    .TXValid(TXValid), .DataIn(DataIn), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_err(tx_err), .tx_bytes(tx_bytes)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a packet is either in flight or not; the gap is an
  // absolute cycle number before which nothing may start.
  int         cyc = 0;
  bit         m_sending, m_is_hs, m_last, m_done;
  logic [7:0] m_datain;
  int         m_bytes, m_err, m_stall, m_quiet_until;

  // Data source: bytes of the current packet; dat_last marks the final one.
  logic [7:0] src_q[$];
  bit         hold = 1'b0;

  // Last sampled DUT outputs.
  logic       o_txv, o_busy, o_done, o_gnt, o_rdy;
  logic [7:0] o_din;
  logic [1:0] o_err;
  logic [10:0] o_bytes;

  task automatic model_reset();
    m_sending = 0; m_is_hs = 0; m_last = 0; m_done = 0;
    m_datain = 8'h00; m_bytes = 0; m_err = 0; m_stall = 0; m_quiet_until = 0;
  endtask

  task automatic drive_src();
    dat_valid = (src_q.size() > 0) && !hold;
    dat_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    dat_last  = (src_q.size() == 1);
  endtask

  task automatic finish_pkt(input bit ok, input int code);
    m_sending = 0;
    m_quiet_until = cyc + IPG + 1;
    m_done = ok;
    m_err = code;
  endtask

  // One clock: drive source, compare at negedge, advance model, end at posedge+1.
  task automatic step();
    bit idle, e_gnt, e_rdy, e_busy, data_err;
    drive_src();
    @(negedge clk_60mhz);
    idle   = !rst && !m_sending && (cyc >= m_quiet_until);
    e_gnt  = idle && !RXActive && hs_req;
    e_rdy  = (idle && !RXActive && !hs_req && dat_valid) ||
             (!rst && m_sending && !m_is_hs && TXReady && !m_last && dat_valid);
    e_busy = !rst && (m_sending || (cyc < m_quiet_until));
    o_txv = TXValid; o_busy = tx_busy; o_done = tx_done; o_gnt = hs_gnt;
    o_rdy = dat_ready; o_din = DataIn; o_err = tx_err; o_bytes = tx_bytes;
    check("TXValid", o_txv, m_sending);
    check("DataIn", o_din, m_datain);
    check("tx_bytes", o_bytes, m_bytes);
    check("tx_done", o_done, m_done);
    check("tx_err", o_err, m_err);
    check("tx_busy", o_busy, e_busy);
    check("hs_gnt", o_gnt, e_gnt);
    check("dat_ready", o_rdy, e_rdy);

    m_done = 0; m_err = 0; data_err = 0;
    if (rst) begin
      model_reset();
    end else if (idle && !RXActive && (hs_req || dat_valid)) begin
      m_sending = 1; m_is_hs = hs_req;
      m_datain = hs_req ? hs_pid : dat_data;
      m_last = hs_req ? 1'b0 : dat_last;
      m_bytes = 0; m_stall = 0;
    end else if (m_sending) begin
      if (TXReady) begin
        m_stall = 0;
        if (m_bytes < 2047) m_bytes++;
        if (m_is_hs || m_last) finish_pkt(1, 0);
        else if (dat_valid) begin m_datain = dat_data; m_last = dat_last; end
        else begin finish_pkt(0, 1); data_err = 1; end
      end else begin
        m_stall++;
        if (m_stall == TO) begin finish_pkt(0, 2); data_err = !m_is_hs; end
      end
    end
    if (e_rdy && dat_valid) void'(src_q.pop_front());
    if (data_err) src_q.delete();
    cyc++;
    @(posedge clk_60mhz);
    #1;
    if (e_gnt) hs_req = 1'b0;
  endtask

  task automatic settle();
    bit ok;
    ok = 0;
    RXActive = 0; TXReady = 1; hold = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (!o_busy && !o_txv && !o_gnt && !o_rdy && !hs_req && src_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("settle", ok, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, n2, gapc, gcyc, dstart, nerr;
    bit ok, errtxv;
    logic [7:0] got[$];
    model_reset();
    #1 rst = 1'b1;
    #2;
    check("rst_TXValid", TXValid, 0);
    check("rst_DataIn", DataIn, 8'h00);
    check("rst_tx_bytes", tx_bytes, 0);
    check("rst_tx_busy", tx_busy, 0);
    @(posedge clk_60mhz); #1;
    step(); step();
    rst = 1'b0;
    step(); step();

    // Handshake: PID held for 3 clocks before TXReady, then done and gap.
    hs_pid = 8'hD2; hs_req = 1; TXReady = 0;
    step();
    check("A_gnt", o_gnt, 1);
    n2 = 0;
    step(); if (o_txv && o_din == 8'hD2) n2++;
    step(); if (o_txv && o_din == 8'hD2) n2++;
    TXReady = 1;
    step(); if (o_txv && o_din == 8'hD2) n2++;
    TXReady = 0;
    check("A_hold", n2, 3);
    step();
    check("A_txv_low", o_txv, 0);
    check("A_done", o_done, 1);
    check("A_bytes", o_bytes, 1);
    hs_pid = 8'h4B; hs_req = 1;
    gapc = o_busy ? 1 : 0;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_busy) gapc++; else begin ok = 1; break; end
    end
    check("A_gap", gapc, IPG);
    check("A_regrant", o_gnt & ok, 1);
    settle();

    // Data packet with TXReady always high.
    src_q = '{8'hC3, 8'h01, 8'h02, 8'h3C};
    TXReady = 1; got.delete(); n2 = 0;
    for (int k = 0; k < IPG + 8; k++) begin
      step();
      if (o_txv) got.push_back(o_din);
      if (o_done) n2++;
    end
    check("B_len", got.size(), 4);
    if (got.size() == 4) begin
      check("B_b0", got[0], 8'hC3); check("B_b1", got[1], 8'h01);
      check("B_b2", got[2], 8'h02); check("B_b3", got[3], 8'h3C);
    end
    check("B_bytes", o_bytes, 4);
    check("B_done", n2, 1);
    settle();

    // Contention under RXActive, then handshake first and data after the gap.
    RXActive = 1; hs_pid = 8'h5A; hs_req = 1; src_q = '{8'h11, 8'h22}; TXReady = 1;
    repeat (3) begin
      step();
      check("C_blk_gnt", o_gnt, 0);
      check("C_blk_rdy", o_rdy, 0);
    end
    RXActive = 0;
    step();
    check("C_gnt", o_gnt, 1);
    check("C_rdy", o_rdy, 0);
    gcyc = cyc - 1; dstart = -1;
    for (int k = 0; k < IPG + 10; k++) begin
      step();
      if (dstart < 0 && o_txv && o_din == 8'h11) dstart = cyc - 1;
    end
    check("C_start", dstart - gcyc, IPG + 3);
    settle();

    // Underrun: source goes invalid when byte 2 is accepted.
    src_q = '{8'hA1, 8'hA2, 8'hA3}; TXReady = 1; hold = 0;
    step(); step();
    hold = 1;
    step();
    check("D_b2", o_din, 8'hA2);
    hold = 0;
    step();
    check("D_txv", o_txv, 0);
    check("D_err", o_err, 2'b01);
    check("D_bytes", o_bytes, 2);
    check("D_busy", o_busy, 1);
    settle();

    // Timeout: TXReady held low.
    hs_pid = 8'h69; hs_req = 1; TXReady = 0;
    step();
    nv = 0; nerr = 0; errtxv = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (o_txv) nv++;
      if (o_err == 2'b10) begin nerr++; errtxv = o_txv; end
    end
    check("E_txv_cycles", nv, TO);
    check("E_err", nerr, 1);
    check("E_err_txv", errtxv, 0);
    settle();

    // Asynchronous reset in the middle of a data packet.
    src_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    TXReady = 0;
    step(); step(); step();
    check("F_pre_txv", o_txv, 1);
    #4 rst = 1'b1;
    #1;
    check("F_txv", TXValid, 0);
    check("F_din", DataIn, 8'h00);
    check("F_busy", tx_busy, 0);
    check("F_rdy", dat_ready, 0);
    check("F_bytes", tx_bytes, 0);
    model_reset();
    src_q.delete();
    step(); step();
    rst = 1'b0;
    step();
    src_q = '{8'hE1, 8'hE2}; TXReady = 1; got.delete(); n2 = 0;
    for (int k = 0; k < IPG + 6; k++) begin
      step();
      if (o_txv) got.push_back(o_din);
      if (o_done) n2++;
    end
    check("F_len", got.size(), 2);
    if (got.size() == 2) begin
      check("F_b0", got[0], 8'hE1); check("F_b1", got[1], 8'hE2);
    end
    check("F_done", n2, 1);
    settle();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (RXActive) RXActive = ($urandom_range(0, 99) >= 30);
      else          RXActive = ($urandom_range(0, 99) < 5);
      TXReady = ($urandom_range(0, 99) < 65);
      if (!hs_req && $urandom_range(0, 99) < 4) begin
        hs_req = 1; hs_pid = 8'($urandom);
      end
      if (src_q.size() == 0 && $urandom_range(0, 99) < 8) begin
        int n;
        n = $urandom_range(1, 6);
        for (int j = 0; j < n; j++) src_q.push_back(8'($urandom));
      end
      hold = ($urandom_range(0, 99) < 12);
      step();
    end
    settle();

    // Long packet: tx_bytes saturates at 2047.
    for (int j = 0; j < 2050; j++) src_q.push_back(8'(j));
    TXReady = 1; nv = 0;
    for (int k = 0; k < 2050 + IPG + 6; k++) begin
      step();
      if (o_txv) nv++;
    end
    check("S_txv_cycles", nv, 2050);
    check("S_bytes", o_bytes, 2047);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/utmi_tx_sched.md
# utmi_tx_sched

Transmit scheduler for the UTMI link-side TX port, in the 60 MHz UTMI clock domain between the protocol engines and the PHY. It arbitrates a single-byte handshake source against a streaming data-packet source and drives `TXValid`/`DataIn` per the UTMI byte handshake. It enforces an inter-packet gap and never starts while the PHY is receiving. It also detects data underrun and a stalled `TXReady`.

## Interface
Parameters:
- `IPG_CYCLES`, default 8: idle clocks forced between end of one packet and start of the next (min 1).
- `TIMEOUT_CYCLES`, default 255: consecutive clocks of `TXValid`=1 and `TXReady`=0 before abort (min 1).

Ports:
- `clk_60mhz`  in  1  UTMI clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `hs_req`  in  1  handshake source requests a one-byte packet.
- `hs_pid`  in  8  handshake PID byte, stable while `hs_req`=1.
- `hs_gnt`  out  1  combinational; PID captured this cycle; source drops `hs_req` next cycle.
- `dat_valid`  in  1  data source has a byte.
- `dat_data`  in  8  data byte.
- `dat_last`  in  1  byte is last of packet.
- `dat_ready`  out  1  combinational; byte transfers when `dat_valid`&`dat_ready`.
- `RXActive`  in  1  PHY receiving; blocks new packet start.
- `TXReady`  in  1  PHY accepted current `DataIn`.
- `TXValid`  out  1  registered; packet in progress.
- `DataIn`  out  8  registered; byte to PHY.
- `tx_busy`  out  1  state ≠ IDLE.
- `tx_done`  out  1  one-clock pulse: packet fully accepted by PHY.
- `tx_err`  out  2  one-clock pulse code: 00 none, 01 underrun, 10 timeout.
- `tx_bytes`  out  11  bytes accepted by PHY in the current/last packet.

## Operation
- States: IDLE, HS, DATA, GAP.
- IDLE: if `RXActive`=1, no grant. Otherwise `hs_req` wins (`hs_gnt`=1, load `DataIn`←`hs_pid`, go to HS). Else if `dat_valid`, `dat_ready`=1, load `DataIn`←`dat_data`, `last_q`←`dat_last`, go to DATA. Either start clears `tx_bytes` to 0 and sets `TXValid`←1.
- Fixed priority: handshake over data, because handshake timing is bus-critical.
- HS: hold byte. On `TXReady`=1: `tx_bytes`←1, `TXValid`←0, `tx_done` pulse, go to GAP.
- DATA: on `TXReady`=1, `tx_bytes`+1. Then:
  - If `last_q`: `TXValid`←0, `tx_done`, go to GAP.
  - Else if `dat_valid`: `dat_ready`=1 in that same cycle, load next byte and `last_q`, stay in DATA.
  - Else underrun: `TXValid`←0, `tx_err`=01, go to GAP.
- `dat_ready`=0 in every other cycle, including all of HS and GAP. `hs_gnt`=0 outside IDLE.
- Timeout: a counter increments each clock with `TXValid`=1 and `TXReady`=0, and clears on `TXReady` or on a new start. Reaching `TIMEOUT_CYCLES` in HS or DATA: `TXValid`←0, `tx_err`=10, go to GAP. The data source must discard the rest of its packet.
- GAP: down-counter loaded with `IPG_CYCLES` on entry; go to IDLE when it reaches 1. `RXActive` is ignored in GAP.
- `RXActive` rising during HS/DATA does not abort; it only gates starts.
- `tx_bytes` saturates at 2047.
- Reset (async, any state): state IDLE; `TXValid`=0, `DataIn`=0x00, `tx_bytes`=0, `tx_done`=0, `tx_err`=00, counters 0. `hs_gnt`/`dat_ready`/`tx_busy` are 0 while `rst`=1.

## Timing
- Start latency: grant in cycle n → `TXValid`=1, `DataIn` valid in n+1.
- A byte with `TXReady`=1 in cycle m is replaced in m+1 (no bubble for back-to-back `TXReady`). `TXValid` falls in m+1 after the last byte.
- `tx_done`/`tx_err` are asserted in cycle m+1, coincident with `TXValid` falling.
- GAP occupies m+1 … m+`IPG_CYCLES`. Earliest next grant is m+`IPG_CYCLES`+1; earliest next `TXValid` is m+`IPG_CYCLES`+2.
- Timeout: `TXValid` high for exactly `TIMEOUT_CYCLES` clocks without `TXReady`, then low on the following clock.
- Simultaneous `hs_req` and `dat_valid` in IDLE: handshake granted, `dat_ready`=0.

## Test plan
- Handshake: `hs_req`=1, `hs_pid`=0xD2, `TXReady` high 3 clocks after `TXValid` → `DataIn`=0xD2 held 3 clocks, then `TXValid` low, `tx_done`=1, `tx_bytes`=1, next start ≥ `IPG_CYCLES`+1 clocks later.
- Data packet 0xC3,0x01,0x02,0x3C(last), `TXReady` always 1 → `TXValid` high exactly 4 clocks, bytes in order, `tx_bytes`=4, `tx_done` once.
- Contention + RX block: `RXActive`=1 with `hs_req` and `dat_valid` both high → no grant; `RXActive` falls → `hs_gnt` first, data packet starts only after handshake + gap.
- Underrun: 3-byte packet, `dat_valid` low when byte 2 accepted → `TXValid` drops next clock, `tx_err`=01, `tx_bytes`=2, GAP entered.
- Timeout with `TIMEOUT_CYCLES`=4: `TXReady` held 0 → `TXValid` high 4 clocks, then low with `tx_err`=10.
- Reset mid-DATA: assert `rst` asynchronously between clock edges → `TXValid`=0, `DataIn`=0, `tx_busy`=0 immediately; clean packet accepted after release.
